// File: rtl/bus_arbiter_if.sv
// Signal bundle between two requesters, the arbiter and the shared memory bus.
// slave is the arbiter's view; master is the view of the surrounding requesters/memory.
interface bus_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_addr;
    logic        req0_we;
    logic [31:0] req0_wdata;
    logic [3:0]  req0_be;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic        rsp0_err;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_addr;
    logic        req1_we;
    logic [31:0] req1_wdata;
    logic [3:0]  req1_be;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic        rsp1_err;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        grant_id;

    modport slave (
        input  req0_valid, req0_addr, req0_we, req0_wdata, req0_be,
        input  req1_valid, req1_addr, req1_we, req1_wdata, req1_be,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_valid, mem_addr, mem_we, mem_wdata, mem_be,
        input  mem_ready, mem_rvalid, mem_rdata,
        output grant_id
    );

    modport master (
        output req0_valid, req0_addr, req0_we, req0_wdata, req0_be,
        output req1_valid, req1_addr, req1_we, req1_wdata, req1_be,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_valid, mem_addr, mem_we, mem_wdata, mem_be,
        output mem_ready, mem_rvalid, mem_rdata,
        input  grant_id
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port round-robin arbiter onto a single-outstanding memory bus, with a
// WAIT-state timeout that answers the owner with an error response.
//
// state | meaning
// IDLE  | no transaction in flight; pick a winner and latch its request
// ISSUE | mem_valid high with latched fields until mem_ready
// WAIT  | waiting for mem_rvalid or timer expiry
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLIMIT = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state, state_nxt;
    logic          win;
    logic          accept;
    logic          ready0, ready1;
    logic          mem_valid;
    logic          rsp_fire;
    logic          rsp_err_nxt;
    logic [31:0]   rsp_data_nxt;

    logic          last_grant;
    logic          grant_id;
    logic [TW-1:0] timer;
    logic [31:0]   addr_q, wdata_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0]   rsp0_rdata, rsp1_rdata;

    // A tie goes to the port that did not win last; a lone requester always wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid)
            win = ~last_grant;
        else
            win = bus.req1_valid;
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        ready0       = 1'b0;
        ready1       = 1'b0;
        mem_valid    = 1'b0;
        rsp_fire     = 1'b0;
        rsp_err_nxt  = 1'b0;
        rsp_data_nxt = '0;
        case (state)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    accept    = 1'b1;
                    ready0    = ~win;
                    ready1    = win;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_valid = 1'b1;
                if (bus.mem_ready)
                    state_nxt = WAIT;
            end
            WAIT: begin
                // Completion beats a timeout landing in the same cycle.
                if (bus.mem_rvalid) begin
                    rsp_fire     = 1'b1;
                    rsp_data_nxt = bus.mem_rdata;
                    state_nxt    = IDLE;
                end else if ((TIMEOUT != 0) && (timer == TLIMIT)) begin
                    rsp_fire    = 1'b1;
                    rsp_err_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            timer      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp1_err   <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= rsp_fire & ~grant_id;
            rsp1_valid <= rsp_fire & grant_id;
            rsp0_err   <= rsp_fire & ~grant_id & rsp_err_nxt;
            rsp1_err   <= rsp_fire & grant_id & rsp_err_nxt;
            rsp0_rdata <= (rsp_fire && !grant_id) ? rsp_data_nxt : '0;
            rsp1_rdata <= (rsp_fire && grant_id) ? rsp_data_nxt : '0;

            if (accept) begin
                grant_id   <= win;
                last_grant <= win;
                addr_q     <= win ? bus.req1_addr  : bus.req0_addr;
                wdata_q    <= win ? bus.req1_wdata : bus.req0_wdata;
                we_q       <= win ? bus.req1_we    : bus.req0_we;
                be_q       <= win ? bus.req1_be    : bus.req0_be;
            end

            if (state == ISSUE)
                timer <= '0;
            else if (state == WAIT && !bus.mem_rvalid)
                timer <= timer + TW'(1);
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.mem_valid  = mem_valid;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_be     = be_q;
    assign bus.rsp0_valid = rsp0_valid;
    assign bus.rsp0_rdata = rsp0_rdata;
    assign bus.rsp0_err   = rsp0_err;
    assign bus.rsp1_valid = rsp1_valid;
    assign bus.rsp1_rdata = rsp1_rdata;
    assign bus.rsp1_err   = rsp1_err;
    assign bus.grant_id   = grant_id;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with TIMEOUT=4: latency, round-robin,
// ISSUE hold, write path, timeout and reset-abandon behaviour.
module tb_bus_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passed = 0;

    bus_arbiter_if bus ();

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_we = 1'b0;
        bus.req0_wdata = '0;   bus.req0_be = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_we = 1'b0;
        bus.req1_wdata = '0;   bus.req1_be = '0;
        bus.mem_ready  = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    endtask

    initial begin
        idle_inputs();
        step(); step();
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
        chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
        chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);

        // Single read on port 1, minimum latency
        bus.req1_valid = 1'b1; bus.req1_addr = 32'h100; bus.req1_we = 1'b0;
        #1;
        chk("rd1_ready1_T", 32'(bus.req1_ready), 32'd1);
        chk("rd1_ready0_T", 32'(bus.req0_ready), 32'd0);
        step();
        bus.req1_valid = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        chk("rd1_mem_valid_T1", 32'(bus.mem_valid), 32'd1);
        chk("rd1_mem_addr_T1", bus.mem_addr, 32'h100);
        chk("rd1_grant_T1", 32'(bus.grant_id), 32'd1);
        step();
        bus.mem_ready = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        #1;
        chk("rd1_mem_valid_T2", 32'(bus.mem_valid), 32'd0);
        chk("rd1_rsp1_T2", 32'(bus.rsp1_valid), 32'd0);
        step();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        chk("rd1_rsp1_valid_T3", 32'(bus.rsp1_valid), 32'd1);
        chk("rd1_rsp1_rdata_T3", bus.rsp1_rdata, 32'hDEADBEEF);
        chk("rd1_rsp1_err_T3", 32'(bus.rsp1_err), 32'd0);
        chk("rd1_rsp0_valid_T3", 32'(bus.rsp0_valid), 32'd0);
        step();
        chk("rd1_rsp1_valid_T4", 32'(bus.rsp1_valid), 32'd0);
        chk("rd1_rsp1_rdata_T4", bus.rsp1_rdata, 32'd0);

        // Round-robin from reset: both ports valid continuously
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 32'hA0;
        bus.req1_valid = 1'b1; bus.req1_addr = 32'hB0;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic exp_port;
            exp_port = (i % 2) != 0;
            chk($sformatf("rr%0d_ready0", i), 32'(bus.req0_ready), 32'(!exp_port));
            chk($sformatf("rr%0d_ready1", i), 32'(bus.req1_ready), 32'(exp_port));
            step();
            bus.mem_ready = 1'b1;
            #1;
            chk($sformatf("rr%0d_grant", i), 32'(bus.grant_id), 32'(exp_port));
            chk($sformatf("rr%0d_addr", i), bus.mem_addr, exp_port ? 32'hB0 : 32'hA0);
            chk($sformatf("rr%0d_no_ready", i), 32'(bus.req0_ready | bus.req1_ready), 32'd0);
            step();
            bus.mem_ready = 1'b0;
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1000 + 32'(i);
            step();
            bus.mem_rvalid = 1'b0;
            #1;
            chk($sformatf("rr%0d_rsp0", i), 32'(bus.rsp0_valid), 32'(!exp_port));
            chk($sformatf("rr%0d_rsp1", i), 32'(bus.rsp1_valid), 32'(exp_port));
            chk($sformatf("rr%0d_rdata", i), exp_port ? bus.rsp1_rdata : bus.rsp0_rdata,
                32'h1000 + 32'(i));
        end
        idle_inputs();
        step();
        step();

        // Write on port 0 with mem_ready held low 5 cycles in ISSUE
        bus.req0_valid = 1'b1; bus.req0_addr = 32'h40; bus.req0_we = 1'b1;
        bus.req0_wdata = 32'h1234; bus.req0_be = 4'b0011;
        #1;
        chk("wr_ready0", 32'(bus.req0_ready), 32'd1);
        step();
        bus.req0_addr = 32'hFFFF_FFFF; bus.req0_we = 1'b0;
        bus.req0_wdata = 32'hFFFF_FFFF; bus.req0_be = 4'b1111;
        bus.req1_valid = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("hold%0d_mem_valid", i), 32'(bus.mem_valid), 32'd1);
            chk($sformatf("hold%0d_addr", i), bus.mem_addr, 32'h40);
            chk($sformatf("hold%0d_we", i), 32'(bus.mem_we), 32'd1);
            chk($sformatf("hold%0d_wdata", i), bus.mem_wdata, 32'h1234);
            chk($sformatf("hold%0d_be", i), 32'(bus.mem_be), 32'b0011);
            chk($sformatf("hold%0d_no_ready", i), 32'(bus.req0_ready | bus.req1_ready), 32'd0);
            chk($sformatf("hold%0d_no_rsp", i), 32'(bus.rsp0_valid | bus.rsp1_valid), 32'd0);
            step();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
        #1;
        chk("wr_wait_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("wr_wait_no_rsp", 32'(bus.rsp0_valid), 32'd0);
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55;
        step();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        chk("wr_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("wr_rsp0_err", 32'(bus.rsp0_err), 32'd0);
        chk("wr_rsp0_rdata", bus.rsp0_rdata, 32'h55);
        step();

        // Timeout: no mem_rvalid, error four cycles after entering WAIT
        bus.req0_valid = 1'b1; bus.req0_addr = 32'h80; bus.req0_we = 1'b0;
        step();
        bus.req0_valid = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_w%0d_no_rsp", i), 32'(bus.rsp0_valid), 32'd0);
            step();
        end
        chk("to_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("to_rsp0_err", 32'(bus.rsp0_err), 32'd1);
        chk("to_rsp0_rdata", bus.rsp0_rdata, 32'd0);
        bus.mem_rvalid = 1'b1;
        step();
        bus.mem_rvalid = 1'b0;
        chk("to_late_rvalid_rsp0", 32'(bus.rsp0_valid), 32'd0);
        step();
        chk("to_late_rvalid_rsp0_b", 32'(bus.rsp0_valid), 32'd0);
        chk("to_late_rvalid_mem_valid", 32'(bus.mem_valid), 32'd0);

        // mem_rvalid coinciding with the timeout cycle wins
        bus.req1_valid = 1'b1; bus.req1_addr = 32'hC0;
        step();
        bus.req1_valid = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step(); step(); step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77;
        step();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        chk("race_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        chk("race_rsp1_err", 32'(bus.rsp1_err), 32'd0);
        chk("race_rsp1_rdata", bus.rsp1_rdata, 32'h77);
        step();

        // Reset pulsed in WAIT abandons the transaction
        bus.req1_valid = 1'b1; bus.req1_addr = 32'hD0;
        step();
        bus.req1_valid = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h99;
        #1;
        chk("rstw_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rstw_grant_id", 32'(bus.grant_id), 32'd0);
        step();
        bus.mem_rvalid = 1'b0;
        chk("rstw_rsp0", 32'(bus.rsp0_valid), 32'd0);
        chk("rstw_rsp1", 32'(bus.rsp1_valid), 32'd0);
        step();
        chk("rstw_rsp1_b", 32'(bus.rsp1_valid), 32'd0);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        chk("rstw_tie_ready0", 32'(bus.req0_ready), 32'd1);
        chk("rstw_tie_ready1", 32'(bus.req1_ready), 32'd0);
        step();
        idle_inputs();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: WAIT-state cycle limit before an error response; 0 disables the timeout.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 reqN_valid (N=0,1)  in  1  requester N presents a transaction; port 0 is instruction fetch, port 1 is data.
REQ-005 reqN_ready  out  1  requester N's transaction is accepted this cycle.
REQ-006 reqN_addr  in  32  byte address.
REQ-007 reqN_we  in  1  1 = write, 0 = read.
REQ-008 reqN_wdata  in  32  write data.
REQ-009 reqN_be  in  4  byte enables.
REQ-010 rspN_valid  out  1  one-cycle response strobe to requester N.
REQ-011 rspN_rdata  out  32  read data; 0 on error.
REQ-012 rspN_err  out  1  response is a timeout error.
REQ-013 mem_valid  out  1  request to the shared memory bus.
REQ-014 mem_ready  in  1  memory accepts the request.
REQ-015 mem_addr / mem_we / mem_wdata / mem_be  out  32/1/32/4  latched request fields.
REQ-016 mem_rvalid  in  1  memory completion, for reads and writes.
REQ-017 mem_rdata  in  32  read data, qualified by mem_rvalid.
REQ-018 grant_id  out  1  owner of the in-flight transaction; holds its last value in IDLE.

Function
REQ-019 The FSM SHALL have three states, IDLE, ISSUE and WAIT; exactly one transaction is outstanding at a time.
REQ-020 In IDLE with any reqN_valid high, the block SHALL select one winner, assert reqN_ready for the winner only (combinational, same cycle), latch its fields and grant_id, and enter ISSUE.
REQ-021 Tie-break SHALL be round-robin: with both valid, the winner is the port not granted last; last_grant updates on each grant.
REQ-022 A lone valid requester SHALL win regardless of last_grant.
REQ-023 reqN_ready SHALL be 0 in ISSUE and WAIT.
REQ-024 In ISSUE, mem_valid SHALL be 1 with the latched fields held stable until mem_ready; on mem_ready the FSM enters WAIT and clears the timer.
REQ-025 mem_rvalid SHALL be sampled only in WAIT; it is ignored in IDLE and ISSUE, including when it coincides with mem_ready.
REQ-026 In WAIT on mem_rvalid, the block SHALL drive, on the next cycle for port grant_id: rspN_valid=1, rspN_rdata=mem_rdata (writes pass mem_rdata unchanged), rspN_err=0; it returns to IDLE.
REQ-027 In WAIT, the timer SHALL increment each cycle without mem_rvalid, using a counter of clog2(TIMEOUT+1) bits.
REQ-028 If TIMEOUT≠0 and the timer reaches TIMEOUT-1 without mem_rvalid, the block SHALL, on the next cycle, drive rspN_valid=1, rspN_err=1, rspN_rdata=0 and return to IDLE.
REQ-029 If mem_rvalid and timeout occur in the same cycle, mem_rvalid SHALL win (err=0).
REQ-030 rsp outputs SHALL be registered; rspN_valid is high exactly one cycle per accepted transaction; rspN_rdata/err are 0 whenever rspN_valid=0.
REQ-031 Minimum latency SHALL be accept at T, mem_valid at T+1, mem_ready at T+1, mem_rvalid at T+2, rsp at T+3.
REQ-032 The block SHALL accept a new request in the IDLE cycle that coincides with a rsp strobe.

Reset
REQ-033 On reset the block SHALL enter IDLE with mem_valid=0, reqN_ready=0, rspN_valid=0, rspN_rdata=0, rspN_err=0, grant_id=0, last_grant=1 (port 0 wins the first tie), timer=0, and latched fields 0.
REQ-034 Reset asserted in ISSUE or WAIT SHALL abandon the transaction without a response; mem_valid is 0 from the next cycle.

Verification
REQ-035 Single read on port 1, addr=0x100, mem_ready immediately, mem_rvalid at T+2 with 0xDEADBEEF -> req1_ready at T; rsp1_valid at T+3 with 0xDEADBEEF, err=0.
REQ-036 Both ports valid continuously for 4 transactions after reset -> grant order 0,1,0,1; no port starved.
REQ-037 mem_ready held low 5 cycles in ISSUE -> mem_addr/we/wdata/be stable throughout; no reqN_ready.
REQ-038 TIMEOUT=4 and mem_rvalid never asserted -> rspN_valid with err=1 and rdata=0 four cycles after entering WAIT; a late mem_rvalid in IDLE is ignored.
REQ-039 Reset pulsed in WAIT, then mem_rvalid -> no rsp strobe; mem_valid=0; the next tie grants port 0.
REQ-040 Write on port 0, be=0b0011, wdata=0x1234 -> mem_we=1, mem_be=0b0011, mem_wdata=0x1234 in ISSUE; rsp0_valid after mem_rvalid, err=0.
